bram_port_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/bram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
// Holds the read-return entry, grant source encoding and index math.
package bram_arb_pkg;

    localparam int ID_MAX_W = 8;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PRIO,
        SRC_LOCK,
        SRC_RR
    } grant_src_e;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } rd_pipe_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Index of the i-th candidate when scanning upward from sh, mod n.
    function automatic int rot_idx(input int i, input int sh, input int n);
        int s;
        s = i + sh;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker for the BRAM port arbiter.
// Finds the first request at or above ptr, wrapping around.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           found
);

    logic [IDW-1:0] cand;

    // Descending scan so the candidate nearest to ptr is kept last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDW'(rot_idx(i, int'(ptr), N));
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// N-master arbiter for one BRAM port with lock and priority override.
// Read data returns through a latency-matched pipeline tagged by master.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 1,
    localparam int IDW = id_width(NUM_MASTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS-1:0]           req,
    input  logic [NUM_MASTERS-1:0]           we,
    input  logic [NUM_MASTERS-1:0]           lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] din,
    input  logic                             prio_en,
    input  logic [IDW-1:0]                   prio_id,
    output logic [NUM_MASTERS-1:0]           gnt,
    output logic [ADDR_WIDTH-1:0]            bram_addr_out,
    output logic [DATA_WIDTH-1:0]            bram_din_out,
    output logic                             bram_en_out,
    output logic                             bram_we_out,
    input  logic [DATA_WIDTH-1:0]            bram_dout,
    output logic [NUM_MASTERS-1:0]           rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data
);

    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         lock_owner;
    logic                   lock_valid;
    logic [NUM_MASTERS-1:0] rr_gnt;
    logic [IDW-1:0]         rr_idx;
    logic                   rr_found;
    logic                   prio_hit;
    logic                   lock_hit;
    grant_src_e             src;
    logic [IDW-1:0]         win;
    logic                   granted;
    logic                   lock_set;
    logic                   lock_clr;
    rd_pipe_t               pipe [RD_LATENCY];

    rr_arbiter #(
        .N(NUM_MASTERS)
    ) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .found(rr_found)
    );

    // Winner selection: priority override, then lock owner, then round-robin.
    always_comb begin
        prio_hit = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (prio_en && prio_id == IDW'(i) && req[i]) begin
                prio_hit = 1'b1;
            end
        end
        lock_hit = lock_valid && req[lock_owner];
        src = SRC_NONE;
        win = '0;
        if (prio_hit) begin
            src = SRC_PRIO;
            win = prio_id;
        end else if (lock_hit) begin
            src = SRC_LOCK;
            win = lock_owner;
        end else if (rr_found) begin
            src = SRC_RR;
            win = rr_idx;
        end
    end

    // Grant and BRAM drive; everything reads zero when nobody wins.
    always_comb begin
        granted       = (src != SRC_NONE);
        gnt           = '0;
        bram_en_out   = 1'b0;
        bram_we_out   = 1'b0;
        bram_addr_out = '0;
        bram_din_out  = '0;
        if (granted) begin
            if (src == SRC_RR) begin
                gnt = rr_gnt;
            end else begin
                gnt[win] = 1'b1;
            end
            bram_en_out   = 1'b1;
            bram_we_out   = we[win];
            bram_addr_out = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            bram_din_out  = din[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lock events; a clear in the same cycle as a set wins.
    always_comb begin
        lock_set = granted && lock[win];
        lock_clr = lock_valid
                 && (!req[lock_owner]
                     || (granted && win == lock_owner && !lock[win]));
    end

    // Round-robin pointer and burst-lock state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
        end else begin
            if (src == SRC_LOCK || src == SRC_RR) begin
                rr_ptr <= (win == IDW'(NUM_MASTERS - 1)) ? '0 : win + IDW'(1);
            end
            if (lock_clr) begin
                lock_valid <= 1'b0;
            end else if (lock_set) begin
                lock_valid <= 1'b1;
                lock_owner <= win;
            end
        end
    end

    // Read-return tag pipeline, matched to the BRAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: granted && !we[win], id: ID_MAX_W'(win)};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Decode the pipeline head into a one-hot strobe and gated data.
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        if (pipe[RD_LATENCY-1].valid) begin
            rd_data = bram_dout;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (pipe[RD_LATENCY-1].id == ID_MAX_W'(i)) begin
                    rd_valid[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic.
// Two instances share stimulus: read latency 1 and read latency 3.
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] din;
    logic            prio_en;
    logic [1:0]      prio_id;

    logic [N-1:0]  gnt, gnt3;
    logic [AW-1:0] b_addr, b_addr3;
    logic [DW-1:0] b_din, b_din3;
    logic          b_en, b_en3, b_we, b_we3;
    logic [DW-1:0] dout1, dout3;
    logic [N-1:0]  rd_valid, rd_valid3;
    logic [DW-1:0] rd_data, rd_data3;

    bram_port_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr(addr), .din(din), .prio_en(prio_en), .prio_id(prio_id),
        .gnt(gnt), .bram_addr_out(b_addr), .bram_din_out(b_din),
        .bram_en_out(b_en), .bram_we_out(b_we), .bram_dout(dout1),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    bram_port_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)
    ) dut3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr(addr), .din(din), .prio_en(prio_en), .prio_id(prio_id),
        .gnt(gnt3), .bram_addr_out(b_addr3), .bram_din_out(b_din3),
        .bram_en_out(b_en3), .bram_we_out(b_we3), .bram_dout(dout3),
        .rd_valid(rd_valid3), .rd_data(rd_data3)
    );

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // BRAM models
    logic        preload;
    logic [31:0] mem1 [2048];
    logic [31:0] mem3 [2048];
    logic [31:0] d3a, d3b;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem1[i] <= init_val(i);
        end else if (b_en && b_we) begin
            mem1[b_addr] <= b_din;
        end
        if (b_en && !b_we) dout1 <= mem1[b_addr];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem3[i] <= init_val(i);
        end else if (b_en3 && b_we3) begin
            mem3[b_addr3] <= b_din3;
        end
        if (b_en3 && !b_we3) d3a <= mem3[b_addr3];
        d3b   <= d3a;
        dout3 <= d3b;
    end

    // Reference model
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ret_t;

    int          m_ptr, m_lkv, m_lko;
    logic [31:0] m_mem [2048];
    ret_t        rq [$];
    int          cyc, win, kind;
    int          n_chk, n_pass;
    logic [48:0] exp_drv;
    logic [35:0] exp_ret;
    wire  [48:0] act_drv = {gnt, b_en, b_we, b_addr, b_din};
    wire  [35:0] act_ret = {rd_valid, rd_data};
    wire  [35:0] act_ret3 = {rd_valid3, rd_data3};

    function automatic void model_eval();
        win  = -1;
        kind = 0;
        if (prio_en && req[prio_id]) begin
            win  = int'(prio_id);
            kind = 1;
        end else if (m_lkv != 0 && req[m_lko]) begin
            win  = m_lko;
            kind = 2;
        end else begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (win < 0 && req[k]) begin
                    win  = k;
                    kind = 3;
                end
            end
        end
        if (win < 0) exp_drv = '0;
        else exp_drv = {4'(1 << win), 1'b1, we[win],
                        addr[win*AW +: AW], din[win*DW +: DW]};
        if (rq.size() > 0 && rq[0].due == cyc)
            exp_ret = {4'(1 << rq[0].id), rq[0].data};
        else
            exp_ret = '0;
    endfunction

    function automatic void model_commit();
        int a;
        bit clr, set;
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        clr = (m_lkv != 0) &&
              (!req[m_lko] || (win == m_lko && !lock[m_lko]));
        set = (win >= 0) && lock[win];
        if (win >= 0) begin
            a = int'(addr[win*AW +: AW]);
            if (we[win]) m_mem[a] = din[win*DW +: DW];
            else rq.push_back('{cyc + 1, win, m_mem[a]});
            if (kind != 1) m_ptr = (win + 1) % N;
        end
        if (clr) m_lkv = 0;
        else if (set) begin
            m_lkv = 1;
            m_lko = win;
        end
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        m_lkv = 0;
        m_lko = 0;
        rq.delete();
    endfunction

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_in();
        req = '0; we = '0; lock = '0; addr = '0; din = '0;
        prio_en = 1'b0; prio_id = '0;
    endtask

    task automatic set_slot(input int m, input logic r, input logic w,
                            input logic l, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        req[m] = r; we[m] = w; lock[m] = l;
        addr[m*AW +: AW] = a;
        din[m*DW +: DW]  = d;
    endtask

    task automatic idle(input int n);
        clear_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (act_drv !== 49'd0)
            $display("FAIL reset_drive got=%h exp=0", act_drv);
        else n_pass++;
        n_chk++;
        if (act_ret !== 36'd0)
            $display("FAIL reset_ret got=%h exp=0", act_ret);
        else n_pass++;
        n_chk++;
        if (act_ret3 !== 36'd0)
            $display("FAIL reset_ret3 got=%h exp=0", act_ret3);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        clear_in();
        for (int i = 0; i < 9; i++) begin
            for (int m = 0; m < N; m++)
                set_slot(m, i < 8, 1'b0, 1'b0, AW'($urandom), '0);
            @(negedge clk);
            model_eval();
            if (i < 8) begin
                n_chk++;
                if (gnt !== 4'(1 << (i % 4)))
                    $display("FAIL rr_seq i=%0d got=%b exp=%b",
                             i, gnt, 4'(1 << (i % 4)));
                else n_pass++;
                n_chk++;
                if (act_drv !== exp_drv)
                    $display("FAIL rr_drive i=%0d got=%h exp=%h",
                             i, act_drv, exp_drv);
                else n_pass++;
            end
            n_chk++;
            if (act_ret !== exp_ret)
                $display("FAIL rr_ret i=%0d got=%h exp=%h",
                         i, act_ret, exp_ret);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] rq_v [3];
        logic [N-1:0] eg [3];
        rq_v[0] = 4'b0100; eg[0] = 4'b0100;
        rq_v[1] = 4'b0011; eg[1] = 4'b0001;
        rq_v[2] = 4'b0011; eg[2] = 4'b0010;
        clear_in();
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < N; m++)
                set_slot(m, rq_v[i][m], 1'b0, 1'b0, AW'(m), '0);
            @(negedge clk);
            n_chk++;
            if (gnt !== eg[i])
                $display("FAIL wrap_gnt step=%0d got=%b exp=%b",
                         i, gnt, eg[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_burst_lock();
        logic [35:0] er;
        clear_in();
        for (int b = 0; b < 6; b++) begin
            clear_in();
            if (b < 4) set_slot(1, 1'b1, 1'b0, b < 3, AW'(16 + b), '0);
            if (b >= 1 && b < 5) set_slot(0, 1'b1, 1'b0, 1'b0, AW'(256), '0);
            @(negedge clk);
            if (b < 5) begin
                n_chk++;
                if (gnt !== ((b < 4) ? 4'b0010 : 4'b0001))
                    $display("FAIL lock_gnt beat=%0d got=%b", b, gnt);
                else n_pass++;
            end
            if (b == 0) er = '0;
            else if (b < 5) er = {4'b0010, m_mem[16 + b - 1]};
            else er = {4'b0001, m_mem[256]};
            n_chk++;
            if (act_ret !== er)
                $display("FAIL lock_ret beat=%0d got=%h exp=%h",
                         b, act_ret, er);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_prio_override();
        logic [N-1:0] rq_v [6];
        logic [N-1:0] lk_v [6];
        logic [N-1:0] eg [6];
        logic         pe [6];
        logic [1:0]   pid [6];
        rq_v[0] = 4'b0100; lk_v[0] = 4'b0100; pe[0] = 0; pid[0] = 0;
        rq_v[1] = 4'b0101; lk_v[1] = 4'b0100; pe[1] = 1; pid[1] = 0;
        rq_v[2] = 4'b0101; lk_v[2] = 4'b0100; pe[2] = 0; pid[2] = 0;
        rq_v[3] = 4'b0101; lk_v[3] = 4'b0000; pe[3] = 0; pid[3] = 0;
        rq_v[4] = 4'b0010; lk_v[4] = 4'b0000; pe[4] = 1; pid[4] = 1;
        rq_v[5] = 4'b0110; lk_v[5] = 4'b0000; pe[5] = 0; pid[5] = 0;
        eg[0] = 4'b0100; eg[1] = 4'b0001; eg[2] = 4'b0100;
        eg[3] = 4'b0100; eg[4] = 4'b0010; eg[5] = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            clear_in();
            for (int m = 0; m < N; m++)
                set_slot(m, rq_v[i][m], 1'b0, lk_v[i][m], AW'(64 + m), '0);
            prio_en = pe[i];
            prio_id = pid[i];
            @(negedge clk);
            model_eval();
            n_chk++;
            if (gnt !== eg[i])
                $display("FAIL prio_gnt step=%0d got=%b exp=%b",
                         i, gnt, eg[i]);
            else n_pass++;
            n_chk++;
            if (act_ret !== exp_ret)
                $display("FAIL prio_ret step=%0d got=%h exp=%h",
                         i, act_ret, exp_ret);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mixed_rw();
        clear_in();
        set_slot(0, 1'b1, 1'b1, 1'b0, 11'h7FF, 32'hDEAD_BEEF);
        @(negedge clk);
        n_chk++;
        if ({gnt, b_en, b_we, b_addr, b_din} !==
            {4'b0001, 1'b1, 1'b1, 11'h7FF, 32'hDEAD_BEEF})
            $display("FAIL rw_write got=%h", act_drv);
        else n_pass++;
        tick();
        clear_in();
        set_slot(1, 1'b1, 1'b0, 1'b0, 11'h7FF, '0);
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0010 || rd_valid !== 4'b0000)
            $display("FAIL rw_read_issue got=%b/%b exp=0010/0000",
                     gnt, rd_valid);
        else n_pass++;
        tick();
        clear_in();
        @(negedge clk);
        n_chk++;
        if (act_ret !== {4'b0010, 32'hDEAD_BEEF})
            $display("FAIL rw_read_ret got=%h exp=%h",
                     act_ret, {4'b0010, 32'hDEAD_BEEF});
        else n_pass++;
        tick();
    endtask

    task automatic test_latency3();
        logic [35:0] e3 [6];
        for (int k = 0; k < 6; k++) e3[k] = '0;
        e3[3] = {4'b1000, m_mem[11'h155]};
        e3[4] = {4'b0100, m_mem[11'h2AA]};
        for (int k = 0; k < 6; k++) begin
            clear_in();
            if (k == 0) set_slot(3, 1'b1, 1'b0, 1'b0, 11'h155, '0);
            if (k == 1) set_slot(2, 1'b1, 1'b0, 1'b0, 11'h2AA, '0);
            @(negedge clk);
            n_chk++;
            if (act_ret3 !== e3[k])
                $display("FAIL lat3_ret k=%0d got=%h exp=%h",
                         k, act_ret3, e3[k]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_flush();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            clear_in();
            set_slot(k, 1'b1, 1'b0, 1'b0, AW'($urandom), '0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (act_ret !== exp_ret)
                $display("FAIL flush_pre k=%0d got=%h exp=%h",
                         k, act_ret, exp_ret);
            else n_pass++;
            if (k < 2) tick();
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (rd_valid !== 4'b0 || rd_valid3 !== 4'b0)
            $display("FAIL flush_assert got=%b/%b exp=0000/0000",
                     rd_valid, rd_valid3);
        else n_pass++;
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if ({act_drv, act_ret, act_ret3} !== '0)
                $display("FAIL flush_after k=%0d got=%h/%h/%h exp=0",
                         k, act_drv, act_ret, act_ret3);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] held;
        held = '0;
        for (int i = 0; i < 400; i++) begin
            clear_in();
            if (i < 396) begin
                for (int m = 0; m < N; m++) begin
                    set_slot(m, held[m] | ($urandom_range(0, 2) == 0),
                             ($urandom_range(0, 2) == 0),
                             ($urandom_range(0, 2) != 0),
                             AW'($urandom_range(0, 31)), $urandom);
                end
                prio_en = ($urandom_range(0, 5) == 0);
                prio_id = 2'($urandom);
            end
            @(negedge clk);
            model_eval();
            n_chk++;
            if (act_drv !== exp_drv)
                $display("FAIL rand_drive i=%0d got=%h exp=%h",
                         i, act_drv, exp_drv);
            else n_pass++;
            n_chk++;
            if (act_ret !== exp_ret)
                $display("FAIL rand_ret i=%0d got=%h exp=%h",
                         i, act_ret, exp_ret);
            else n_pass++;
            held = req & ~((win >= 0) ? 4'(1 << win) : 4'b0);
            tick();
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cyc     = 0;
        rst     = 1'b1;
        preload = 1'b1;
        clear_in();
        model_reset();
        for (int i = 0; i < 2048; i++) m_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        test_reset();
        test_round_robin();
        idle(2);
        test_wrap();
        idle(2);
        test_burst_lock();
        idle(2);
        test_prio_override();
        idle(2);
        test_mixed_rw();
        idle(4);
        test_latency3();
        idle(4);
        test_reset_flush();
        idle(4);
        test_random();
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
